// File: rtl/pea_rcfg_sequencer_if.sv
// Control/status bundle between the Mage control registers, the PEA stall
// source and the reconfiguration sequencer. The master side drives launch,
// abort, window configuration and back-pressure; the slave (sequencer) drives
// the context address and status pulses.
interface pea_rcfg_sequencer_if #(
    parameter int N_ADDR_BITS_KMEM = 3,
    parameter int CNT_W            = 16
);
    logic                        start_i;
    logic                        abort_i;
    logic [N_ADDR_BITS_KMEM-1:0] cfg_start_addr_i;
    logic [N_ADDR_BITS_KMEM-1:0] cfg_end_addr_i;
    logic [CNT_W-1:0]            cfg_dwell_i;
    logic [CNT_W-1:0]            cfg_iters_i;
    logic                        stall_i;
    logic [N_ADDR_BITS_KMEM-1:0] rcfg_ctrl_addr_o;
    logic                        ctx_valid_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        err_o;

    modport master (
        output start_i, abort_i, cfg_start_addr_i, cfg_end_addr_i,
               cfg_dwell_i, cfg_iters_i, stall_i,
        input  rcfg_ctrl_addr_o, ctx_valid_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, abort_i, cfg_start_addr_i, cfg_end_addr_i,
               cfg_dwell_i, cfg_iters_i, stall_i,
        output rcfg_ctrl_addr_o, ctx_valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/pea_rcfg_sequencer.sv
// Time-multiplexing controller for the PEA reconfiguration memory.
// Walks a programmed window [start..end] of KMEM contexts, holding each one
// for dwell cycles, and repeats the window for a programmed number of passes.
// Configuration is captured in shadow registers when a launch is accepted so
// the control registers may be reprogrammed while a sequence is running.
module pea_rcfg_sequencer #(
    parameter int KMEM_SIZE        = 8,
    parameter int N_ADDR_BITS_KMEM = $clog2(KMEM_SIZE),
    parameter int CNT_W            = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pea_rcfg_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [N_ADDR_BITS_KMEM:0] KMEM_LIM = KMEM_SIZE[N_ADDR_BITS_KMEM:0];

    state_t                      r_state;
    logic [N_ADDR_BITS_KMEM-1:0] r_addr;
    logic [CNT_W-1:0]            r_dwell_cnt;
    logic [CNT_W-1:0]            r_iter_cnt;
    logic                        r_err;

    // shadow copies of the window configuration, valid from launch onwards
    logic [N_ADDR_BITS_KMEM-1:0] r_start;
    logic [N_ADDR_BITS_KMEM-1:0] r_end;
    logic [CNT_W-1:0]            r_dwell;
    logic [CNT_W-1:0]            r_iters;

    state_t                      w_state_nxt;
    logic [N_ADDR_BITS_KMEM-1:0] w_addr_nxt;
    logic [CNT_W-1:0]            w_dwell_nxt;
    logic [CNT_W-1:0]            w_iter_nxt;
    logic                        w_err_nxt;
    logic                        w_latch;
    logic                        w_bad_window;
    logic [CNT_W-1:0]            w_dwell_last;
    logic                        w_dwell_end;
    logic                        w_last_iter;

    // a window is illegal if it runs backwards or past the last context
    assign w_bad_window = (bus.cfg_end_addr_i < bus.cfg_start_addr_i) ||
                          ({1'b0, bus.cfg_end_addr_i} >= KMEM_LIM);

    // a programmed dwell of 0 behaves like 1: last count index is 0 either way
    assign w_dwell_last = (r_dwell == '0) ? '0 : (r_dwell - 1'b1);
    assign w_dwell_end  = (r_dwell_cnt == w_dwell_last);
    assign w_last_iter  = (r_iter_cnt == (r_iters - 1'b1));

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and next-datapath decode; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_dwell_nxt = r_dwell_cnt;
        w_iter_nxt  = r_iter_cnt;
        w_err_nxt   = 1'b0;
        w_latch     = 1'b0;

        if (bus.abort_i) begin
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
            w_dwell_nxt = '0;
            w_iter_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (w_bad_window) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_latch     = 1'b1;
                            w_dwell_nxt = '0;
                            w_iter_nxt  = '0;
                            if (bus.cfg_iters_i == '0) begin
                                w_state_nxt = FINISH;
                            end else begin
                                w_state_nxt = RUN;
                                w_addr_nxt  = bus.cfg_start_addr_i;
                            end
                        end
                    end
                end
                RUN: begin
                    if (!bus.stall_i) begin
                        if (!w_dwell_end) begin
                            w_dwell_nxt = r_dwell_cnt + 1'b1;
                        end else if (r_addr != r_end) begin
                            w_addr_nxt  = r_addr + 1'b1;
                            w_dwell_nxt = '0;
                        end else if (!w_last_iter) begin
                            w_addr_nxt  = r_start;
                            w_iter_nxt  = r_iter_cnt + 1'b1;
                            w_dwell_nxt = '0;
                        end else begin
                            w_state_nxt = FINISH;
                            w_dwell_nxt = '0;
                        end
                    end
                end
                FINISH: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // address, counters and error pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_dwell_cnt <= '0;
            r_iter_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_iter_cnt  <= w_iter_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // capture the configuration only when a launch is accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_start <= '0;
            r_end   <= '0;
            r_dwell <= '0;
            r_iters <= '0;
        end else if (w_latch) begin
            r_start <= bus.cfg_start_addr_i;
            r_end   <= bus.cfg_end_addr_i;
            r_dwell <= bus.cfg_dwell_i;
            r_iters <= bus.cfg_iters_i;
        end
    end

    assign bus.rcfg_ctrl_addr_o = r_addr;
    assign bus.ctx_valid_o      = (r_state == RUN);
    assign bus.busy_o           = (r_state != IDLE);
    assign bus.done_o           = (r_state == FINISH);
    assign bus.err_o            = r_err;

endmodule
